// File: rtl/en_strobe_gen.sv
// Purpose : periodic one-cycle enable strobe generator, finite-burst or continuous.
// Latency : first en one cycle after an accepted start (plus phase offset when enabled).
// Backpressure: none; stop aborts immediately (next cycle idle), start is ignored while running.
//
// Ports:
//   clk, rst      - sole clock, synchronous active-high reset
//   start, stop   - begin a sequence (IDLE only) / abort the running sequence
//   period [CW]   - strobe interval in cycles (0 behaves as 1), latched on start
//   burst  [BW]   - strobes per sequence (0 = continuous), latched on start
//   phase  [CW]   - optional first-strobe delay, present only with STROBE_GEN_PHASE_EN
//   en            - one-cycle strobe
//   busy          - high while running
//   done          - one-cycle pulse after a finite burst completes
//   count  [BW]   - strobes issued in the current or last sequence
//
// Build option: define STROBE_GEN_PHASE_EN to add the phase input.
module en_strobe_gen #(
    parameter int CW = 8,
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [CW-1:0] period,
    input  logic [BW-1:0] burst,
`ifdef STROBE_GEN_PHASE_EN
    input  logic [CW-1:0] phase,
`endif
    output logic          en,
    output logic          busy,
    output logic          done,
    output logic [BW-1:0] count
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state, state_d;
    logic [CW-1:0] pm1_q, pm1_d;      // latched period minus one
    logic [CW-1:0] ph_q, ph_d;        // cycles remaining until the next strobe
    logic [BW-1:0] burst_q, burst_d;
    logic [BW-1:0] count_d;
    logic          en_d, done_d;

    logic          accept;
    logic          last;
    logic [CW-1:0] start_pm1;
    logic [CW-1:0] ph0;

    assign accept    = (state == IDLE) && start && !stop;
    // The strobe on the wire right now is the final one of a finite burst.
    // The burst_q guard keeps continuous mode from ending when count wraps.
    assign last      = en && (burst_q != '0) && ((count + BW'(1)) == burst_q);
    assign start_pm1 = (period == '0) ? '0 : period - CW'(1);

`ifdef STROBE_GEN_PHASE_EN
    assign ph0 = phase;
`else
    assign ph0 = '0;
`endif

    assign busy = (state == RUN);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pm1_q   <= '0;
            ph_q    <= '0;
            burst_q <= '0;
            count   <= '0;
            en      <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            pm1_q   <= pm1_d;
            ph_q    <= ph_d;
            burst_q <= burst_d;
            count   <= count_d;
            en      <= en_d;
            done    <= done_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (stop || last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        pm1_d   = pm1_q;
        burst_d = burst_q;
        ph_d    = ph_q;
        en_d    = 1'b0;
        done_d  = 1'b0;
        // count tracks strobes already seen, so it trails en by one cycle
        count_d = en ? count + BW'(1) : count;
        case (state)
            IDLE: begin
                if (accept) begin
                    pm1_d   = start_pm1;
                    burst_d = burst;
                    count_d = '0;
                    if (ph0 == '0) begin
                        en_d = 1'b1;
                        ph_d = start_pm1;
                    end else begin
                        ph_d = ph0 - CW'(1);
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    // abort: the strobe that would have come next is dropped
                    ph_d = '0;
                end else if (last) begin
                    done_d = 1'b1;
                    ph_d   = '0;
                end else if (ph_q == '0) begin
                    en_d = 1'b1;
                    ph_d = pm1_q;
                end else begin
                    ph_d = ph_q - CW'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_en_strobe_gen.sv
// Purpose : self-checking bench for en_strobe_gen using a per-cycle expectation queue.
// Latency : expectations are stamped with the cycle in which the outputs must appear.
// Backpressure: n/a; the bench drives every cycle and checks on the falling edge.
module tb_en_strobe_gen;

    localparam int CW = 8;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [CW-1:0] period;
    logic [BW-1:0] burst;
`ifdef STROBE_GEN_PHASE_EN
    logic [CW-1:0] phase;
`endif
    logic          en;
    logic          busy;
    logic          done;
    logic [BW-1:0] count;

    en_strobe_gen #(.CW(CW), .BW(BW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .period (period),
        .burst  (burst),
`ifdef STROBE_GEN_PHASE_EN
        .phase  (phase),
`endif
        .en     (en),
        .busy   (busy),
        .done   (done),
        .count  (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             cyc;
        logic           en;
        logic           busy;
        logic           done;
        logic [BW-1:0]  count;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   last_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Scoreboard consumer: compare every expectation due in this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("en",    {31'b0, en},   {31'b0, e.en});
            chk("busy",  {31'b0, busy}, {31'b0, e.busy});
            chk("done",  {31'b0, done}, {31'b0, e.done});
            chk("count", {24'b0, count}, {24'b0, e.count});
        end
    end

    function automatic exp_t mk(input int c, input bit e, input bit b, input bit d, input int n);
        exp_t r;
        r.cyc   = c;
        r.en    = e;
        r.busy  = b;
        r.done  = d;
        r.count = n[BW-1:0];
        return r;
    endfunction

    // Hold idle inputs for len cycles, expecting a quiet IDLE with count held.
    task automatic idle(input int len, input bit st, input bit sp, input int exp_cnt);
        start = st;
        stop  = sp;
        for (int t = 1; t <= len; t++) begin
            @(posedge clk); #1;
            q.push_back(mk(cyc, 1'b0, 1'b0, 1'b0, exp_cnt));
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Start a sequence in the current cycle n and expect outputs for n+1..n+len.
    // stop_t / rst_t: assert stop / rst during cycle n+t (0 = never).
    // noise: toggle start and scramble period/burst while running.
    task automatic run(input int p, input int b, input int ph, input int len,
                       input int stop_t, input int rst_t, input bit noise);
        int peff, cnt, n;
        bit running, done_next, e_en;
        peff      = (p == 0) ? 1 : p;
        cnt       = 0;
        running   = 1'b1;
        done_next = 1'b0;
        n         = cyc;
        start  = 1'b1;
        stop   = 1'b0;
        period = p[CW-1:0];
        burst  = b[BW-1:0];
`ifdef STROBE_GEN_PHASE_EN
        phase  = ph[CW-1:0];
`endif
        for (int t = 1; t <= len; t++) begin
            @(posedge clk); #1;
            e_en = running && (t - 1 >= ph) && (((t - 1 - ph) % peff) == 0);
            q.push_back(mk(n + t, e_en, running, done_next, cnt));
            done_next = 1'b0;
            start = (noise && running) ? 1'($urandom_range(0, 1)) : 1'b0;
            stop  = (t == stop_t);
            rst   = (t == rst_t);
            if (noise) begin
                period = CW'($urandom);
                burst  = BW'($urandom);
            end
            if (running && e_en) cnt++;
            if (t == rst_t) begin
                running = 1'b0;
                cnt     = 0;
            end else if (running && t == stop_t) begin
                running = 1'b0;
            end else if (running && b > 0 && e_en && cnt == b) begin
                running   = 1'b0;
                done_next = 1'b1;
            end
        end
        start    = 1'b0;
        stop     = 1'b0;
        rst      = 1'b0;
        last_cnt = cnt % (1 << BW);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        period = '0;
        burst  = '0;
`ifdef STROBE_GEN_PHASE_EN
        phase  = '0;
`endif
        // two reset cycles: outputs zero after each reset edge
        @(posedge clk); #1;
        q.push_back(mk(cyc, 1'b0, 1'b0, 1'b0, 0));
        @(posedge clk); #1;
        q.push_back(mk(cyc, 1'b0, 1'b0, 1'b0, 0));
        rst = 1'b0;
        idle(2, 1'b0, 1'b0, 0);

        // period 3, burst 4: en at +1,+4,+7,+10, done at +11, count 4
        run(3, 4, 0, 12, 0, 0, 1'b0);
        idle(2, 1'b0, 1'b0, last_cnt);

        // period 0 behaves as 1: en +1..+5, done +6
        run(0, 5, 0, 7, 0, 0, 1'b0);
        idle(1, 1'b0, 1'b0, last_cnt);

        // burst of one, then a new start in the done cycle (with noise while running)
        run(1, 1, 0, 2, 0, 0, 1'b0);
        run(2, 3, 0, 6, 0, 0, 1'b1);
        idle(2, 1'b0, 1'b0, last_cnt);

        // start and stop together in IDLE: stop wins
        idle(3, 1'b1, 1'b1, last_cnt);

        // continuous, period 3: stop in the cycle before a due strobe suppresses it
        run(3, 0, 0, 8, 6, 0, 1'b1);
        idle(2, 1'b0, 1'b0, last_cnt);

        // reset mid-burst at count 2 of 6
        run(2, 6, 0, 6, 0, 4, 1'b0);
        idle(2, 1'b0, 1'b0, 0);

        // continuous period 2: count wraps after 256 strobes, then stop
        run(2, 0, 0, 518, 516, 0, 1'b0);
        idle(2, 1'b0, 1'b0, last_cnt);

`ifdef STROBE_GEN_PHASE_EN
        // phase 5, period 4, burst 2: en at +6, +10, done at +11
        run(4, 2, 5, 12, 0, 0, 1'b0);
        idle(2, 1'b0, 1'b0, last_cnt);
`endif

        repeat (3) @(posedge clk);
        #1;
        if (q.size() != 0) chk("drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/en_strobe_gen.md
EN_STROBE_GEN -- requirements
Module: en_strobe_gen

Interface
REQ-001 Parameter CW, default 8, width of period counter and period input.
REQ-002 Parameter BW, default 8, width of burst length and strobe count.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  begin a strobe sequence; sampled only in IDLE.
REQ-007 stop  input  1  abort the running sequence.
REQ-008 period  input  CW  strobe interval in cycles; 0 treated as 1; latched on accepted start.
REQ-009 burst  input  BW  strobes per sequence; 0 = continuous; latched on accepted start.
REQ-010 en  output  1  one-cycle strobe, drives a downstream register's enable.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  one-cycle pulse after a finite burst completes.
REQ-013 count  output  BW  strobes issued in current or last sequence.

Function
REQ-014 The FSM SHALL have states IDLE and RUN; all outputs SHALL be registered.
REQ-015 start=1, stop=0 in IDLE at cycle n: state RUN at n+1, period/burst latched, count cleared to 0.
REQ-016 The first en SHALL assert at cycle n+1, then every P cycles (P = latched period, 0 -> 1); P=1 gives en continuously high.
REQ-017 A phase down-counter SHALL reload P-1 on each strobe and decrement otherwise; en asserts in RUN when it reaches 0.
REQ-018 count SHALL increment with each en; in continuous mode it SHALL wrap modulo 2^BW.
REQ-019 For burst B>0, on the cycle of the B-th en the FSM SHALL leave RUN; busy=0 and done=1 for exactly the next cycle.
REQ-020 count SHALL hold its final value in IDLE until the next accepted start.
REQ-021 start during RUN SHALL be ignored; period/burst changes during RUN SHALL have no effect.
REQ-022 stop=1 in RUN SHALL suppress en that cycle and return to IDLE next cycle, with no done pulse.
REQ-023 start and stop both high in IDLE: stop wins, state stays IDLE.
REQ-024 start in the done cycle SHALL be accepted (state is IDLE).

Reset
REQ-025 rst=1 SHALL force IDLE and en=0, busy=0, done=0, count=0, phase counter=0 at the next edge.
REQ-026 rst SHALL take priority over start/stop; reset mid-RUN aborts without done.

Configuration
REQ-027 Macro STROBE_GEN_PHASE_EN defined: input phase [CW-1:0] SHALL exist, latched on start; first en at n+1+phase, then every P.
REQ-028 Macro STROBE_GEN_PHASE_EN undefined: no phase port; first en at n+1 per REQ-016.

Verification
REQ-029 rst 2 cycles -> en/busy/done/count all 0; start at n, period=3, burst=4 -> en at n+1,n+4,n+7,n+10; done at n+11; count=4.
REQ-030 period=0, burst=5 -> en high n+1..n+5 inclusive, done at n+6, busy low from n+6.
REQ-031 burst=0, period=2, BW=8 -> en every 2 cycles; after 256 strobes count wraps to 0; stop -> no done, busy low next cycle.
REQ-032 stop in same cycle a strobe is due -> en stays 0; start+stop in IDLE -> stays IDLE; start in RUN ignored.
REQ-033 rst asserted mid-burst (count=2 of 6) -> all outputs 0 next cycle, no done; start in done cycle -> new run, count reset.
REQ-034 With STROBE_GEN_PHASE_EN, phase=5, period=4, burst=2 -> en at n+6, n+10; done at n+11.
